// File: rtl/fat32_cluster_chain_reader.sv
// fat32_cluster_chain_reader: walks a FAT32 cluster chain and streams the absolute data sector addresses in chain order
//
// Ports:
//   Clock, sys_rst_n           clock and asynchronous active-low reset
//   start, firstCluster        begin a walk at the given cluster (ignored while busy)
//   fatStartSector             absolute sector of FAT #1
//   dataStartSector            absolute sector of cluster 2
//   SectorsPerCluster          cluster size in sectors (0 aborts the walk)
//   sectorReadRequest/Address  FAT sector read request, held until sectorReadAck
//   isEdit/EditAddress/EditByte  incoming FAT sector byte stream
//   sectorReadDone             end of the FAT sector byte stream
//   dataSectorValid/dataSector/dataSectorReady  data sector address handshake
//   busy, chainEnd, chainError, clusterCount    walk status
//
// Optional feature: define FAT_SECTOR_CACHE_EN to keep the last FAT sector in a
// 512x8 RAM, so hops that stay within that sector skip the SD read.
module fat32_cluster_chain_reader #(
  parameter int          theSizeofSectors = 512,
  parameter logic [31:0] MaxChainLength   = 32'h00100000
) (
  input  logic        Clock,
  input  logic        sys_rst_n,
  input  logic        start,
  input  logic [31:0] firstCluster,
  input  logic [31:0] fatStartSector,
  input  logic [31:0] dataStartSector,
  input  logic [7:0]  SectorsPerCluster,
  output logic        sectorReadRequest,
  output logic [31:0] sectorReadAddress,
  input  logic        sectorReadAck,
  input  logic        isEdit,
  input  logic [8:0]  EditAddress,
  input  logic [7:0]  EditByte,
  input  logic        sectorReadDone,
  output logic        dataSectorValid,
  output logic [31:0] dataSector,
  input  logic        dataSectorReady,
  output logic        busy,
  output logic        chainEnd,
  output logic        chainError,
  output logic [31:0] clusterCount
);
  localparam int SH = $clog2(theSizeofSectors / 4);
  typedef enum logic [3:0] {IDLE, CHECK, EMIT, REQ, WAIT, EVAL, DONE, ERROR, CACHE_RD} state_t;
  state_t state, nstate;
  logic [31:0] cur, entry, fat_addr, dsec;
  logic [7:0] idx;
  logic last, hit, bad;
`ifdef FAT_SECTOR_CACHE_EN
  logic [7:0] mem [512];
  logic [31:0] cached_sector;
  logic cache_valid;
  logic [1:0] ridx;
  assign hit = cache_valid && cached_sector == fat_addr;
  always_ff @(posedge Clock)
    if (state == WAIT && isEdit) mem[EditAddress] <= EditByte;
`else
  assign hit = 1'b0;
`endif
  assign fat_addr = fatStartSector + (cur >> SH);
  assign dsec = dataStartSector + (cur - 32'd2) * {24'd0, SectorsPerCluster} + {24'd0, idx};
  assign last = idx == SectorsPerCluster - 8'd1;
  assign bad = SectorsPerCluster == 8'd0 || cur < 32'd2 || cur == 32'h0FFFFFF7;
  always_comb begin
    nstate = state;
    busy = !(state inside {IDLE, DONE, ERROR});
    dataSectorValid = state == EMIT;
    dataSector = dataSectorValid ? dsec : 32'd0;
    sectorReadRequest = state == REQ && !hit;
    sectorReadAddress = sectorReadRequest ? fat_addr : 32'd0;
    case (state)
      IDLE, DONE, ERROR: nstate = start ? CHECK : state;
      CHECK:    nstate = bad ? ERROR : cur >= 32'h0FFFFFF8 ? DONE : EMIT;
      EMIT:     nstate = dataSectorReady && last ? REQ : EMIT;
      REQ:      nstate = hit ? CACHE_RD : sectorReadAck ? WAIT : REQ;
      WAIT:     nstate = sectorReadDone ? EVAL : WAIT;
      EVAL:     nstate = clusterCount >= MaxChainLength ? ERROR : CHECK;
`ifdef FAT_SECTOR_CACHE_EN
      CACHE_RD: nstate = ridx == 2'd3 ? EVAL : CACHE_RD;
`endif
      default:  nstate = IDLE;
    endcase
  end
  always_ff @(posedge Clock or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state <= IDLE;
      cur <= '0;
      entry <= '0;
      idx <= '0;
      clusterCount <= '0;
      chainEnd <= 1'b0;
      chainError <= 1'b0;
`ifdef FAT_SECTOR_CACHE_EN
      cached_sector <= '0;
      cache_valid <= 1'b0;
      ridx <= '0;
`endif
    end else begin
      state <= nstate;
      if (start && !busy) begin
        cur <= firstCluster & 32'h0FFFFFFF;
        idx <= '0;
        clusterCount <= '0;
        chainEnd <= 1'b0;
        chainError <= 1'b0;
`ifdef FAT_SECTOR_CACHE_EN
        cache_valid <= 1'b0;
`endif
      end
      if (state == CHECK) chainEnd <= nstate == DONE;
      if (state == CHECK || state == EVAL) chainError <= nstate == ERROR;
      if (state == EMIT && dataSectorReady) begin
        idx <= last ? 8'd0 : idx + 8'd1;
        if (last) clusterCount <= clusterCount + 32'd1;
      end
      // only the 4 bytes of the current cluster's entry are kept
      if (state == WAIT && isEdit && EditAddress[8:2] == cur[6:0])
        entry[{EditAddress[1:0], 3'b000} +: 8] <= EditByte;
      if (state == EVAL) cur <= entry & 32'h0FFFFFFF;
`ifdef FAT_SECTOR_CACHE_EN
      if (state == REQ && !hit && sectorReadAck) cached_sector <= fat_addr;
      if (state == WAIT && sectorReadDone) cache_valid <= 1'b1;
      if (state == CACHE_RD) begin
        entry[{ridx, 3'b000} +: 8] <= mem[{cur[6:0], ridx}];
        ridx <= ridx + 2'd1;
      end
`endif
    end
endmodule

// File: tb/tb_fat32_cluster_chain_reader.sv
// tb_fat32_cluster_chain_reader: directed scoreboard bench for fat32_cluster_chain_reader
module tb_fat32_cluster_chain_reader;
  logic Clock = 0, sys_rst_n = 0, start = 0;
  logic [31:0] firstCluster = 0, fatStartSector = 32'h20, dataStartSector = 32'h2000;
  logic [7:0] SectorsPerCluster = 1;
  logic sectorReadAck = 0, isEdit = 0, sectorReadDone = 0, dataSectorReady = 1;
  logic [8:0] EditAddress = 0;
  logic [7:0] EditByte = 0;
  logic sectorReadRequest, dataSectorValid, busy, chainEnd, chainError;
  logic [31:0] sectorReadAddress, dataSector, clusterCount;
  int errors = 0, checks = 0, vcnt = 0, rcnt = 0, v0, r0;
  logic [31:0] expq[$], reqq[$];
  logic [31:0] fat[int];
  logic [31:0] a, e, ei;

  fat32_cluster_chain_reader #(.theSizeofSectors(512), .MaxChainLength(32'd4)) dut (
    .Clock(Clock), .sys_rst_n(sys_rst_n), .start(start), .firstCluster(firstCluster),
    .fatStartSector(fatStartSector), .dataStartSector(dataStartSector),
    .SectorsPerCluster(SectorsPerCluster), .sectorReadRequest(sectorReadRequest),
    .sectorReadAddress(sectorReadAddress), .sectorReadAck(sectorReadAck), .isEdit(isEdit),
    .EditAddress(EditAddress), .EditByte(EditByte), .sectorReadDone(sectorReadDone),
    .dataSectorValid(dataSectorValid), .dataSector(dataSector), .dataSectorReady(dataSectorReady),
    .busy(busy), .chainEnd(chainEnd), .chainError(chainError), .clusterCount(clusterCount));

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fat_rd(input logic [31:0] c);
    return fat.exists(int'(c)) ? fat[int'(c)] : 32'd0;
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin @(posedge Clock); #1; end
  endtask

  task automatic go(input logic [31:0] f, input logic [7:0] spc);
    firstCluster = f;
    SectorsPerCluster = spc;
    start = 1;
    cyc(1);
    start = 0;
  endtask

  task automatic finish_walk(input string tag, input logic [31:0] cc, input logic en, input logic er);
    for (int i = 0; i < 5000 && busy; i++) cyc(1);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_count"}, clusterCount, cc);
    chk({tag, "_end"}, 32'(chainEnd), 32'(en));
    chk({tag, "_err"}, 32'(chainError), 32'(er));
    chk({tag, "_sectors_left"}, 32'(expq.size()), 0);
    chk({tag, "_reqs_left"}, 32'(reqq.size()), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req"}, 32'(sectorReadRequest), 0);
    chk({tag, "_raddr"}, sectorReadAddress, 0);
    chk({tag, "_valid"}, 32'(dataSectorValid), 0);
    chk({tag, "_dsec"}, dataSector, 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_end"}, 32'(chainEnd), 0);
    chk({tag, "_err"}, 32'(chainError), 0);
    chk({tag, "_count"}, clusterCount, 0);
  endtask

  // data sector consumer: every accepted address is compared with the scoreboard
  always @(negedge Clock)
    if (sys_rst_n && dataSectorValid) begin
      vcnt++;
      if (dataSectorReady) chk("sector", dataSector, expq.size() != 0 ? expq.pop_front() : 32'hDEADBEEF);
    end

  // FAT sector reader model: ack, then 512 bytes with done on the last byte
  initial forever begin
    @(posedge Clock); #1;
    if (sys_rst_n && sectorReadRequest) begin
      a = sectorReadAddress;
      rcnt++;
      chk("fat_req_addr", a, reqq.size() != 0 ? reqq.pop_front() : 32'hDEADBEEF);
      sectorReadAck = 1;
      @(posedge Clock); #1;
      sectorReadAck = 0;
      for (int i = 0; i < 512; i++) begin
        if (!sys_rst_n) break;
        ei = (a - fatStartSector) * 128 + 32'(i / 4);
        e = fat_rd(ei);
        isEdit = 1;
        EditAddress = i[8:0];
        EditByte = e[8 * (i % 4) +: 8];
        sectorReadDone = i == 511;
        @(posedge Clock); #1;
      end
      isEdit = 0;
      sectorReadDone = 0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    cyc(2);
    chk_zero("reset");
    sys_rst_n = 1;
    cyc(1);
    fat[5] = 32'h0FFFFFFF;
    expq.push_back(32'h2003);
    reqq.push_back(32'h20);
    go(32'h10000005, 8'd1);
    finish_walk("t1", 1, 1, 0);
    fat[5] = 32'hF0000006;
    fat[6] = 32'h0FFFFFFF;
    for (int i = 0; i < 16; i++) expq.push_back(32'h2018 + 32'(i));
    reqq.push_back(32'h20);
`ifndef FAT_SECTOR_CACHE_EN
    reqq.push_back(32'h20);
`endif
    go(32'd5, 8'd8);
    finish_walk("t2", 2, 1, 0);
    v0 = vcnt;
    r0 = rcnt;
    go(32'd1, 8'd8);
    cyc(1);
    chk("t3_low_err", 32'(chainError), 1);
    go(32'h0FFFFFF7, 8'd8);
    cyc(1);
    chk("t3_bad_err", 32'(chainError), 1);
    go(32'd5, 8'd0);
    cyc(1);
    chk("t3_spc0_err", 32'(chainError), 1);
    chk("t3_no_valid", 32'(vcnt - v0), 0);
    chk("t3_no_req", 32'(rcnt - r0), 0);
    fat[3] = 32'h0FFFFFFF;
    dataSectorReady = 0;
    for (int i = 0; i < 4; i++) expq.push_back(32'h2004 + 32'(i));
    reqq.push_back(32'h20);
    go(32'd3, 8'd4);
    cyc(1);
    for (int i = 0; i < 10; i++) begin
      chk("t4_hold_valid", 32'(dataSectorValid), 1);
      chk("t4_hold_sector", dataSector, 32'h2004);
      cyc(1);
    end
    dataSectorReady = 1;
    finish_walk("t4", 1, 1, 0);
    fat[32'h7F] = 32'h80;
    fat[32'h80] = 32'h0FFFFFFF;
    expq.push_back(32'h207D);
    expq.push_back(32'h207E);
    reqq.push_back(32'h20);
    reqq.push_back(32'h21);
    go(32'h7F, 8'd1);
    finish_walk("t5_cross", 2, 1, 0);
    fat[5] = 32'd5;
    for (int i = 0; i < 4; i++) expq.push_back(32'h2003);
`ifdef FAT_SECTOR_CACHE_EN
    reqq.push_back(32'h20);
`else
    for (int i = 0; i < 4; i++) reqq.push_back(32'h20);
`endif
    go(32'd5, 8'd1);
    finish_walk("t5_loop", 4, 0, 1);
    fat[5] = 32'h0FFFFFFF;
    expq.push_back(32'h2003);
    reqq.push_back(32'h20);
    go(32'd5, 8'd1);
    for (int i = 0; i < 50 && !isEdit; i++) cyc(1);
    chk("t6_in_wait", 32'(isEdit), 1);
    cyc(5);
    #2 sys_rst_n = 0;
    #1 chk_zero("t6_async");
    cyc(3);
    sys_rst_n = 1;
    cyc(2);
    chk("t6_idle", 32'(busy), 0);
    expq.push_back(32'h2003);
    reqq.push_back(32'h20);
    go(32'd5, 8'd1);
    finish_walk("t6", 1, 1, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
